// File: rtl/fma_recomplement_normalizer.sv
// FMA post-adder stage: recovers the true magnitude from a ones'-complement sum, then
// normalizes it through a 3-stage valid/ready pipeline (recomplement, LZC, shift).
module fma_recomplement_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:0] sum_in,
  input  logic        control_in,
  input  logic        sign_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] mant_out,
  output logic [6:0]  exp_adj,
  output logic        sticky_out,
  output logic        sign_out,
  output logic        zero_out
);

  logic        s1_valid_q, s1_sign_q;
  logic [48:0] s1_mag_q;
  logic        s2_valid_q, s2_sign_q, s2_zero_q;
  logic [48:0] s2_mag_q;
  logic [5:0]  s2_lz_q;
  logic        s3_valid_q, s3_sticky_q, s3_sign_q, s3_zero_q;
  logic [47:0] s3_mant_q;
  logic [6:0]  s3_exp_q;

  logic        s1_adv, s2_adv, s3_adv;
  logic [48:0] s1_mag_d;
  logic        s1_sign_d;
  logic [5:0]  s2_lz_d;
  logic        s2_zero_d;
  logic [47:0] s3_mant_d;
  logic [6:0]  s3_exp_d;
  logic        s3_sticky_d, s3_sign_d;

  // Each stage may load when it is empty or its contents move on this cycle.
  assign s3_adv   = !s3_valid_q | out_ready;
  assign s2_adv   = !s2_valid_q | s3_adv;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: undo the ones'-complement; a missing carry means B > A, so the sign flips.
  always_comb begin
    s1_mag_d  = sum_in;
    s1_sign_d = sign_in;
    if (control_in) begin
      if (sum_in[48]) begin
        s1_mag_d = {1'b0, sum_in[47:0]} + 49'd1;
      end else begin
        s1_mag_d  = {1'b0, ~sum_in[47:0]};
        s1_sign_d = ~sign_in;
      end
    end
  end

  // Stage 2: leading-zero count of the low 48 bits; the highest set bit wins.
  always_comb begin
    s2_lz_d = '0;
    for (int i = 0; i < 48; i++) begin
      if (s1_mag_q[i]) begin
        s2_lz_d = 6'(47 - i);
      end
    end
    s2_zero_d = (s1_mag_q == 49'd0);
  end

  // Stage 3: carry-out needs a 1-bit right shift, otherwise shift left by the LZ count.
  always_comb begin
    s3_mant_d   = s2_mag_q[47:0] << s2_lz_q;
    s3_exp_d    = 7'd0 - {1'b0, s2_lz_q};
    s3_sticky_d = 1'b0;
    s3_sign_d   = s2_sign_q;
    if (s2_mag_q[48]) begin
      s3_mant_d   = s2_mag_q[48:1];
      s3_exp_d    = 7'd1;
      s3_sticky_d = s2_mag_q[0];
    end else if (s2_zero_q) begin
      s3_mant_d = '0;
      s3_exp_d  = '0;
      s3_sign_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_mag_q    <= '0;
      s2_lz_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_sticky_q <= 1'b0;
      s3_sign_q   <= 1'b0;
      s3_zero_q   <= 1'b0;
      s3_mant_q   <= '0;
      s3_exp_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mag_q  <= s1_mag_d;
          s1_sign_q <= s1_sign_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_mag_q  <= s1_mag_q;
          s2_sign_q <= s1_sign_q;
          s2_lz_q   <= s2_lz_d;
          s2_zero_q <= s2_zero_d;
        end
      end
      if (s3_adv) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_mant_q   <= s3_mant_d;
          s3_exp_q    <= s3_exp_d;
          s3_sticky_q <= s3_sticky_d;
          s3_sign_q   <= s3_sign_d;
          s3_zero_q   <= s2_zero_q;
        end
      end
    end
  end

  assign out_valid  = s3_valid_q;
  assign mant_out   = s3_mant_q;
  assign exp_adj    = s3_exp_q;
  assign sticky_out = s3_sticky_q;
  assign sign_out   = s3_sign_q;
  assign zero_out   = s3_zero_q;

endmodule

// File: tb/tb_fma_recomplement_normalizer.sv
// Directed bench for fma_recomplement_normalizer: arithmetic vectors, latency,
// backpressure ordering/stability and mid-flight reset.
module tb_fma_recomplement_normalizer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, control_in, sign_in;
  logic [48:0] sum_in;
  logic        out_valid, out_ready, sticky_out, sign_out, zero_out;
  logic [47:0] mant_out;
  logic [6:0]  exp_adj;

  int total = 0;
  int bad = 0;

  fma_recomplement_normalizer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .control_in (control_in),
    .sign_in    (sign_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_out   (mant_out),
    .exp_adj    (exp_adj),
    .sticky_out (sticky_out),
    .sign_out   (sign_out),
    .zero_out   (zero_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // Sends one beat into an empty pipeline and checks latency and every output field.
  task automatic run_vec(input string tag, input logic [48:0] s, input logic c, input logic sg,
                         input logic [47:0] m, input logic [6:0] e, input logic st,
                         input logic so, input logic z);
    int n;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    sum_in     = s;
    control_in = c;
    sign_in    = sg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, "_lat"}, 64'(n), 64'd3);
    check_val({tag, "_mant"}, 64'(mant_out), 64'(m));
    check_val({tag, "_exp"}, 64'(exp_adj), 64'(e));
    check_val({tag, "_sticky"}, 64'(sticky_out), 64'(st));
    check_val({tag, "_sign"}, 64'(sign_out), 64'(so));
    check_val({tag, "_zero"}, 64'(zero_out), 64'(z));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, seen;
    logic acc, have;
    logic [57:0] held;
    logic [47:0] rx[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sum_in = '0; control_in = 1'b0; sign_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_mant", 64'(mant_out), 64'd0);
    check_val("rst_exp", 64'(exp_adj), 64'd0);
    check_val("rst_sticky", 64'(sticky_out), 64'd0);
    check_val("rst_sign", 64'(sign_out), 64'd0);
    check_val("rst_zero", 64'(zero_out), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    // tag, sum, ctrl, sign_in -> mant, exp_adj, sticky, sign_out, zero
    run_vec("add", 49'h0_8000_0000_0000, 1'b0, 1'b1, 48'h8000_0000_0000, 7'h00, 1'b0, 1'b1, 1'b0);
    run_vec("addc", 49'h1_0000_0000_0003, 1'b0, 1'b0, 48'h8000_0000_0001, 7'h01, 1'b1, 1'b0, 1'b0);
    run_vec("subp", 49'h1_8000_0000_0001, 1'b1, 1'b0, 48'h8000_0000_0002, 7'h00, 1'b0, 1'b0, 1'b0);
    run_vec("subn", 49'h0_FFFF_FFFF_FFFC, 1'b1, 1'b0, 48'hC000_0000_0000, 7'h52, 1'b0, 1'b1, 1'b0);
    run_vec("subz", 49'h0_FFFF_FFFF_FFFF, 1'b1, 1'b1, 48'h0, 7'h00, 1'b0, 1'b0, 1'b1);
    run_vec("addz", 49'h0_0000_0000_0000, 1'b0, 1'b1, 48'h0, 7'h00, 1'b0, 1'b0, 1'b1);
    run_vec("lz47", 49'h0_0000_0000_0001, 1'b0, 1'b1, 48'h8000_0000_0000, 7'h51, 1'b0, 1'b1, 1'b0);
    run_vec("eac", 49'h1_FFFF_FFFF_FFFF, 1'b1, 1'b1, 48'h8000_0000_0000, 7'h01, 1'b0, 1'b1, 1'b0);
    run_vec("addall", 49'h1_FFFF_FFFF_FFFF, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 7'h01, 1'b1, 1'b0, 1'b0);
    run_vec("subtop", 49'h0_7FFF_FFFF_FFFF, 1'b1, 1'b1, 48'h8000_0000_0000, 7'h00, 1'b0, 1'b0, 1'b0);

    // Backpressure: 6 stalled cycles, then drain; beat k carries mantissa 0x8000..0 + k + 1.
    idx = 0;
    have = 1'b0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c >= 6);
      if (idx < 5) begin
        in_valid   = 1'b1;
        control_in = 1'b0;
        sign_in    = 1'b0;
        sum_in     = 49'h0_8000_0000_0000 + 49'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid & in_ready;
      if (out_valid) begin
        if (!out_ready) begin
          if (have) begin
            check_val("stall_hold", 64'({mant_out, exp_adj, sticky_out, sign_out, zero_out}),
                      64'(held));
          end
          held = {mant_out, exp_adj, sticky_out, sign_out, zero_out};
          have = 1'b1;
        end else begin
          rx.push_back(mant_out);
        end
      end
      if (c == 5) begin
        check_val("bp_accepted", 64'(idx), 64'd3);
        check_val("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      if (acc) idx++;
      #1;
      if (rx.size() == 5) break;
    end
    in_valid = 1'b0;
    check_val("bp_count", 64'(rx.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx.size()) check_val("bp_order", 64'(rx[i]), 64'(48'h8000_0000_0000 + 48'(i + 1)));
    end

    // Reset with two beats in flight and a third offered during the reset cycle.
    repeat (3) @(posedge clk);
    #1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    control_in = 1'b0;
    sum_in     = 49'h0_8000_0000_0011;
    @(posedge clk);
    #1;
    sum_in = 49'h0_8000_0000_0022;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    sum_in = 49'h0_8000_0000_0033;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_val("mrst_out_valid", 64'(out_valid), 64'd0);
    check_val("mrst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_val("mrst_no_emit", 64'(seen), 64'd0);

    run_vec("post", 49'h0_0000_0001_0000, 1'b0, 1'b0, 48'h8000_0000_0000, 7'h51 + 7'd16, 1'b0,
            1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fma_recomplement_normalizer.md
FMA_RECOMPLEMENT_NORMALIZER -- requirements
Module: fma_recomplement_normalizer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  input beat present.
REQ-004 in_ready  out  1  block accepts beat this cycle; transfer = in_valid & in_ready.
REQ-005 sum_in  in  49  raw adder result; bit48 = adder carry-out, [47:0] = sum of 48-bit mantissa A and conditionally ones'-complemented B.
REQ-006 control_in  in  1  1 = B was ones'-complemented (effective subtraction); 0 = B passed unchanged (effective addition).
REQ-007 sign_in  in  1  sign of operand A.
REQ-008 out_valid  out  1  output beat present.
REQ-009 out_ready  in  1  downstream accepts; transfer = out_valid & out_ready.
REQ-010 mant_out  out  48  normalized magnitude, leading 1 at bit 47 unless zero_out.
REQ-011 exp_adj  out  7  signed two's-complement exponent correction, range -47..+1.
REQ-012 sticky_out  out  1  OR of bits shifted out by a right shift.
REQ-013 sign_out  out  1  result sign.
REQ-014 zero_out  out  1  exact-zero result.

Function
REQ-015 Block SHALL recover true magnitude from ones'-complement sum.
REQ-016 control_in=0: magnitude (49-bit) = sum_in; sign_out = sign_in.
REQ-017 control_in=1, sum_in[48]=1: magnitude = sum_in[47:0] + 1 (end-around carry), zero-extended to 49 bits; sign_out = sign_in.
REQ-018 control_in=1, sum_in[48]=0: magnitude = ~sum_in[47:0]; sign_out = ~sign_in.
REQ-019 Magnitude bit48 set: mant_out = magnitude[48:1], exp_adj = +1, sticky_out = magnitude[0].
REQ-020 Else magnitude nonzero: lz = leading zeros of magnitude[47:0] (0..47); mant_out = magnitude[47:0] << lz; exp_adj = -lz; sticky_out = 0.
REQ-021 Magnitude zero: zero_out=1, mant_out=0, exp_adj=0, sticky_out=0, sign_out=0 (forced +0), regardless of control_in/sign_in.
REQ-022 Pipeline SHALL be 3 registered stages: S1 recomplement + sign; S2 leading-zero count; S3 shift + output register; all outputs driven from S3 registers.
REQ-023 Latency SHALL be exactly 3 cycles from input transfer to out_valid with out_ready held 1; throughput 1 beat/cycle.
REQ-024 Each stage SHALL advance when its successor is empty or advancing; S3 advances when !out_valid | out_ready.
REQ-025 in_ready = !S1_valid | S1 advances (combinational from out_ready through stage chain); no extra buffering.
REQ-026 While out_valid=1 and out_ready=0, all output ports SHALL hold stable.
REQ-027 Beats SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-028 Input transfer and output transfer in same cycle with full pipeline SHALL both complete.
REQ-029 sum_in with control_in=1 and value 0x1_FFFF_FFFF_FFFF is unreachable; behaviour follows REQ-017/019 arithmetically, no flag.

Reset
REQ-030 rst=1 at clock edge SHALL clear all stage valids and zero all data registers: out_valid=0, mant_out=0, exp_adj=0, sticky_out=0, sign_out=0, zero_out=0.
REQ-031 in_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-032 rst mid-operation SHALL discard all in-flight beats; an input presented during the rst cycle is not accepted.

Verification
REQ-033 Add: control_in=0, sum_in=0x0_8000_0000_0000, sign_in=1 -> 3 cycles later mant_out=0x8000_0000_0000, exp_adj=0, sticky=0, sign_out=1, zero_out=0.
REQ-034 Add carry: control_in=0, sum_in=0x1_0000_0000_0003 -> mant_out=0x8000_0000_0001, exp_adj=+1, sticky_out=1.
REQ-035 Sub positive (A=0x8000_0000_0003, B=1): control_in=1, sum_in=0x1_8000_0000_0001, sign_in=0 -> mant_out=0x8000_0000_0002, exp_adj=0, sign_out=0.
REQ-036 Sub negative (A=1, B=4): control_in=1, sum_in=0x0_FFFF_FFFF_FFFC, sign_in=0 -> mant_out=0xC000_0000_0000, exp_adj=-46 (0x52), sign_out=1; zero case sum_in=0x0_FFFF_FFFF_FFFF, sign_in=1 -> zero_out=1, mant_out=0, sign_out=0.
REQ-037 Backpressure: 5 back-to-back beats, out_ready=0 for 6 cycles -> in_ready falls after 3 accepted, outputs stable while stalled, all 5 emerge in order once out_ready=1.
REQ-038 Reset mid-flight: 2 beats in pipeline, rst pulsed 1 cycle -> out_valid=0 next cycle, neither beat ever emitted, in_ready=1 after rst.
